// File: rtl/vi_ctrl_pkg.sv
// Shared definitions for the PI-D controller slice.
//   GAIN_FRAC : fractional bits of the Q4.12 gains
//   DATA_W    : sample / gain / term width
//   ACC_W     : width of the three-term sum before the duty clamp
//   state_e   : sequencer states
//   clamp()   : signed 32-bit clamp to [lo, hi]
//   sat16()   : signed saturation of a 32-bit value to 16 bits
package vi_ctrl_pkg;

    localparam int GAIN_FRAC = 12;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    function automatic logic signed [31:0] clamp(input logic signed [31:0] x,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        return 16'(clamp(x, -32'sd32768, 32'sd32767));
    endfunction

endpackage

// File: rtl/pid_mul_shift.sv
// Registered signed 16x16 multiply, rescaled from Q4.12 x Q1.15 back to
// Q1.15 by an arithmetic shift of GAIN_FRAC, then saturated to 16 bits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : signed operands (gain, data)
//   y          : sat16((a*b) >>> GAIN_FRAC), one cycle after the operands
module pid_mul_shift
    import vi_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    logic signed [31:0] prod;

    assign prod = 32'(a) * 32'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= sat16(prod >>> GAIN_FRAC);
        end
    end

endmodule

// File: rtl/pid_ctrl_core.sv
// PI-D compute stage with a run/fault sequencer.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reg_kp/reg_ki/reg_kd       : signed Q4.12 gains, latched when a sample is captured
//   reg_vref                   : signed Q1.15 setpoint
//   reg_start, reg_clear_fault : one-cycle command pulses
//   adc_valid, adc_data        : sample strobe and signed Q1.15 measurement
//   duty, duty_valid           : clamped duty word and its one-cycle update pulse
//   running, fault             : sequencer state flags
//   busy                       : compute schedule in progress
//   overrun                    : sticky, a sample arrived while busy
// One shared multiplier walks a fixed schedule after the capture edge T0:
// phase 1 computes p, phase 2 the integral increment, phase 3 the derivative
// term; phase 4 sums and phase 5 publishes the duty.
module pid_ctrl_core
    import vi_ctrl_pkg::*;
#(
    parameter logic signed [15:0] OV_LIMIT  = 16'sh7000,
    parameter int unsigned        FAULT_CNT = 3,
    parameter logic [15:0]        INT_LIM   = 16'h7FFF,
    parameter logic [15:0]        DUTY_MAX  = 16'h7FFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] reg_kp,
    input  logic signed [DATA_W-1:0] reg_ki,
    input  logic signed [DATA_W-1:0] reg_kd,
    input  logic signed [DATA_W-1:0] reg_vref,
    input  logic                     reg_start,
    input  logic                     reg_clear_fault,
    input  logic                     adc_valid,
    input  logic signed [DATA_W-1:0] adc_data,
    output logic        [DATA_W-1:0] duty,
    output logic                     duty_valid,
    output logic                     running,
    output logic                     fault,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic signed [31:0] INT_HI  = $signed({16'd0, INT_LIM});
    localparam logic signed [31:0] INT_LO  = -INT_HI;
    localparam logic signed [31:0] DUTY_HI = $signed({16'd0, DUTY_MAX});

    state_e                    state_reg;
    logic [2:0]                phase_reg;
    logic signed [DATA_W-1:0]  kp_reg, ki_reg, kd_reg;
    logic signed [DATA_W-1:0]  e_reg, e_prev_reg, p_reg, acc_reg;
    logic signed [ACC_W-1:0]   u_reg;
    logic [3:0]                fcnt_reg;
    logic [DATA_W-1:0]         duty_reg;
    logic                      duty_valid_reg, overrun_reg;

    logic                      capture, trip;
    logic [3:0]                fcnt_next;
    logic signed [DATA_W-1:0]  err_next, de, acc_next;
    logic signed [ACC_W-1:0]   u_next;
    logic [DATA_W-1:0]         duty_next;
    logic signed [DATA_W-1:0]  mul_a, mul_b, mul_y;

    assign busy       = (phase_reg != 3'd0);
    assign capture    = (state_reg == ST_RUN) && adc_valid && !busy;
    assign fcnt_next  = (adc_data > OV_LIMIT) ? fcnt_reg + 4'd1 : 4'd0;
    // A tripping sample never enters the schedule.
    assign trip       = capture && (fcnt_next == 4'(FAULT_CNT));
    assign err_next   = sat16(32'(reg_vref) - 32'(adc_data));
    assign de         = sat16(32'(e_reg) - 32'(e_prev_reg));
    // The multiplier register holds the integral increment at the phase-3 edge.
    assign acc_next   = 16'(clamp(32'(acc_reg) + 32'(mul_y), INT_LO, INT_HI));
    // At the phase-4 edge the multiplier register holds the derivative term.
    assign u_next     = ACC_W'(p_reg) + ACC_W'(acc_reg) + ACC_W'(mul_y);
    assign duty_next  = 16'(clamp(32'(u_reg), 32'sd0, DUTY_HI));

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (phase_reg)
            3'd1:    begin mul_a = kp_reg; mul_b = e_reg; end
            3'd2:    begin mul_a = ki_reg; mul_b = e_reg; end
            3'd3:    begin mul_a = kd_reg; mul_b = de;    end
            default: ;
        endcase
    end

    pid_mul_shift u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (mul_a),
        .b     (mul_b),
        .y     (mul_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= 3'd0;
            kp_reg         <= '0;
            ki_reg         <= '0;
            kd_reg         <= '0;
            e_reg          <= '0;
            e_prev_reg     <= '0;
            p_reg          <= '0;
            acc_reg        <= '0;
            u_reg          <= '0;
            fcnt_reg       <= '0;
            duty_reg       <= '0;
            duty_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            duty_valid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (reg_start) begin
                        state_reg  <= ST_RUN;
                        acc_reg    <= '0;
                        e_prev_reg <= '0;
                        fcnt_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    if (capture) begin
                        fcnt_reg <= fcnt_next;
                        if (trip) begin
                            state_reg <= ST_FAULT;
                        end else begin
                            e_reg     <= err_next;
                            kp_reg    <= reg_kp;
                            ki_reg    <= reg_ki;
                            kd_reg    <= reg_kd;
                            phase_reg <= 3'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    // Clear has priority; a simultaneous start is dropped.
                    if (reg_clear_fault) begin
                        state_reg <= ST_IDLE;
                        acc_reg   <= '0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            case (phase_reg)
                3'd1: phase_reg <= 3'd2;
                3'd2: begin
                    p_reg     <= mul_y;
                    phase_reg <= 3'd3;
                end
                3'd3: begin
                    acc_reg    <= acc_next;
                    e_prev_reg <= e_reg;
                    phase_reg  <= 3'd4;
                end
                3'd4: begin
                    u_reg     <= u_next;
                    phase_reg <= 3'd5;
                end
                3'd5: begin
                    duty_reg       <= duty_next;
                    duty_valid_reg <= 1'b1;
                    phase_reg      <= 3'd0;
                end
                default: ;
            endcase

            if (state_reg == ST_FAULT) duty_reg <= '0;

            // A new overrun in the same cycle as a clear stays visible.
            if (reg_clear_fault)   overrun_reg <= 1'b0;
            if (adc_valid && busy) overrun_reg <= 1'b1;
        end
    end

    assign duty       = duty_reg;
    assign duty_valid = duty_valid_reg;
    assign running    = (state_reg == ST_RUN);
    assign fault      = (state_reg == ST_FAULT);
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_pid_ctrl_core.sv
module tb_pid_ctrl_core;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] reg_kp = '0, reg_ki = '0, reg_kd = '0, reg_vref = '0;
    logic               reg_start = 1'b0, reg_clear_fault = 1'b0;
    logic               adc_valid = 1'b0;
    logic signed [15:0] adc_data = '0;
    logic [15:0]        duty;
    logic               duty_valid, running, fault, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    pid_ctrl_core dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .reg_kp          (reg_kp),
        .reg_ki          (reg_ki),
        .reg_kd          (reg_kd),
        .reg_vref        (reg_vref),
        .reg_start       (reg_start),
        .reg_clear_fault (reg_clear_fault),
        .adc_valid       (adc_valid),
        .adc_data        (adc_data),
        .duty            (duty),
        .duty_valid      (duty_valid),
        .running         (running),
        .fault           (fault),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int clampi(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Q4.12 gain times Q1.15 value, back to Q1.15, saturated.
    function automatic int mulq(input int g, input int e);
        return clampi((g * e) >>> 12, -32768, 32767);
    endfunction

    // Model state: 0 idle, 1 run, 2 fault.
    int m_st = 0, m_acc = 0, m_eprev = 0, m_fcnt = 0;
    int m_duty = 0, m_dv = 0, m_ov = 0;
    int m_pend = 0, m_due = 0, m_val = 0, cyc = 0;

    initial begin
        int busy_pre, st_pre, e, p, d, u;
        forever begin
            @(posedge clk or negedge rst_n);
            cyc++;
            if (!rst_n) begin
                m_st = 0; m_acc = 0; m_eprev = 0; m_fcnt = 0;
                m_duty = 0; m_dv = 0; m_ov = 0; m_pend = 0;
            end else begin
                busy_pre = m_pend;
                st_pre   = m_st;
                m_dv     = 0;
                if (m_pend != 0 && cyc == m_due) begin
                    m_duty = m_val;
                    m_dv   = 1;
                    m_pend = 0;
                end
                if (reg_clear_fault) m_ov = 0;
                if (adc_valid && busy_pre != 0) m_ov = 1;
                case (st_pre)
                    0: if (reg_start) begin
                        m_st = 1; m_acc = 0; m_eprev = 0; m_fcnt = 0;
                    end
                    1: if (adc_valid && busy_pre == 0) begin
                        m_fcnt = (s16(adc_data) > 32'sh7000) ? m_fcnt + 1 : 0;
                        if (m_fcnt == 3) begin
                            m_st = 2;
                        end else begin
                            e       = clampi(s16(reg_vref) - s16(adc_data), -32768, 32767);
                            p       = mulq(s16(reg_kp), e);
                            m_acc   = clampi(m_acc + mulq(s16(reg_ki), e), -32767, 32767);
                            d       = mulq(s16(reg_kd), clampi(e - m_eprev, -32768, 32767));
                            m_eprev = e;
                            u       = p + m_acc + d;
                            m_val   = clampi(u, 0, 32767);
                            m_pend  = 1;
                            m_due   = cyc + 5;
                        end
                    end
                    default: if (reg_clear_fault) begin
                        m_st = 0; m_acc = 0;
                    end
                endcase
                if (st_pre == 2) m_duty = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("duty",       int'(duty),       m_duty);
            check("duty_valid", int'(duty_valid), m_dv);
            check("running",    int'(running),    int'(m_st == 1));
            check("fault",      int'(fault),      int'(m_st == 2));
            check("busy",       int'(busy),       m_pend);
            check("overrun",    int'(overrun),    m_ov);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        reg_start = 1'b1; tick(); reg_start = 1'b0;
    endtask

    task automatic pulse_clear();
        reg_clear_fault = 1'b1; tick(); reg_clear_fault = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    endtask

    // One sample, then a fixed 10-cycle window; lat is edges after capture.
    task automatic send(input logic [15:0] adc, output int val, output int lat);
        adc_valid = 1'b1;
        adc_data  = adc;
        val = -1;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) adc_valid = 1'b0;
            if (duty_valid && lat < 0) begin
                lat = n - 1;
                val = int'(duty);
            end
        end
        $display("sample adc=0x%04h -> duty=%0d latency=%0d", adc, val, lat);
    endtask

    initial begin
        int v, l, dvc;

        tick(); tick(); tick();
        check("rst_duty",    int'(duty),       0);
        check("rst_valid",   int'(duty_valid), 0);
        check("rst_busy",    int'(busy),       0);
        check("rst_running", int'(running),    0);
        check("rst_fault",   int'(fault),      0);
        check("rst_overrun", int'(overrun),    0);
        rst_n = 1'b1;
        tick();

        // P-only
        reg_kp = 16'sh1000; reg_ki = 16'sh0; reg_kd = 16'sh0; reg_vref = 16'sh4000;
        pulse_start();
        check("t1_running", int'(running), 1);
        send(16'h2000, v, l);
        check("t1_duty", v, 32'h2000);
        check("t1_lat",  l, 5);

        // I-only accumulation
        do_reset();
        reg_kp = 16'sh0; reg_ki = 16'sh1000;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send(16'h3000, v, l);
            check("t2_duty", v, (i + 1) * 32'h1000);
        end

        // Saturation at both ends
        do_reset();
        reg_kp = 16'sh4000; reg_ki = 16'sh0;
        pulse_start();
        send(16'h0000, v, l);
        check("t3_sat_hi", v, 32'h7FFF);
        reg_kp = 16'sh1000;
        send(16'h6000, v, l);
        check("t3_sat_lo", v, 0);
        check("t3_sat_lo_lat", l, 5);

        // Fault trip and clear
        do_reset();
        pulse_start();
        send(16'h7100, v, l);
        check("t4_s1_lat", l, 5);
        send(16'h7100, v, l);
        check("t4_s2_lat", l, 5);
        send(16'h7100, v, l);
        check("t4_s3_no_valid", l, -1);
        check("t4_fault",   int'(fault),   1);
        check("t4_running", int'(running), 0);
        check("t4_duty",    int'(duty),    0);
        pulse_start();
        check("t4_start_ignored", int'(fault), 1);
        pulse_clear();
        check("t4_cleared", int'(fault),   0);
        check("t4_idle",    int'(running), 0);

        // Overrun
        pulse_start();
        adc_valid = 1'b1; adc_data = 16'sh2000;
        tick(); tick();
        adc_valid = 1'b0;
        dvc = 0;
        for (int n = 0; n < 10; n++) begin
            dvc += int'(duty_valid);
            tick();
        end
        check("t5_one_valid", dvc, 1);
        check("t5_overrun",   int'(overrun), 1);
        pulse_clear();
        check("t5_overrun_clr", int'(overrun), 0);
        check("t5_still_run",   int'(running), 1);

        // Asynchronous reset mid-compute
        adc_valid = 1'b1; adc_data = 16'sh1000;
        tick();
        adc_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("t6_duty", int'(duty), 0);
        check("t6_busy", int'(busy), 0);
        dvc = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (n == 1) rst_n = 1'b1;
            dvc += int'(duty_valid);
        end
        check("t6_no_valid", dvc, 0);
        send(16'h2000, v, l);
        check("t6_idle_ignored", l, -1);
        check("t6_idle_busy", int'(busy), 0);

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst_n           = ($urandom_range(0, 599) != 0);
            reg_start       = ($urandom_range(0, 15) == 0);
            reg_clear_fault = ($urandom_range(0, 39) == 0);
            adc_valid       = ($urandom_range(0, 2) == 0);
            adc_data        = ($urandom_range(0, 2) == 0) ?
                              16'(32'h7001 + $urandom_range(0, 32'h0FFE)) : 16'($urandom);
            if ($urandom_range(0, 3) == 0) reg_kp   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) reg_ki   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) reg_kd   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) reg_vref = 16'($urandom);
            tick();
        end
        rst_n = 1'b1; reg_start = 1'b0; reg_clear_fault = 1'b0; adc_valid = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
